// File: rtl/wshb_slave_mem_if.sv
// Wishbone classic-cycle bus bundle between one master and the memory slave.
interface wshb_slave_mem_if #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 32
);
  logic [AWIDTH-1:0]   wb_adr_i;
  logic [DWIDTH-1:0]   wb_dat_i;
  logic [DWIDTH/8-1:0] wb_sel_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [DWIDTH-1:0]   wb_dat_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wshb_slave_mem.sv
// Wishbone classic-cycle slave backed by on-chip word memory. Supports
// programmable wait states, byte-lane writes, an error response for
// out-of-range words and periodic retry injection. All outputs registered.
module wshb_slave_mem #(
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 32,
  parameter int DEPTH     = 1024,
  parameter int WAIT      = 0,
  parameter int RTY_EVERY = 0
) (
  input logic             clk,
  input logic             rst,
  wshb_slave_mem_if.slave bus
);

  localparam int LANES = DWIDTH / 8;
  localparam int OFFS  = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RC_W  = (RTY_EVERY > 0) ? $clog2(RTY_EVERY + 1) : 1;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        wait_cnt_q;
  logic [RC_W-1:0]   rty_cnt_q;
  logic              rty_mark_q;
  logic [AWIDTH-1:0] adr_q;
  logic [DWIDTH-1:0] dat_q;
  logic [LANES-1:0]  sel_q;
  logic              we_q;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              accept;
  logic              fire;
  logic              wait_dec;
  logic              resp_ack;
  logic              resp_err;
  logic              resp_rty;
  logic [AWIDTH-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic [RC_W-1:0]   rty_cnt_inc;
  logic              rty_hit;

  // Decode the latched byte address into a word index and range flag.
  always_comb begin
    word_idx    = adr_q >> OFFS;
    mem_idx     = word_idx[IDX_W-1:0];
    in_range    = {1'b0, word_idx} < DEPTH_W;
    rty_cnt_inc = rty_cnt_q + RC_W'(1);
    rty_hit     = (RTY_EVERY > 0) && (rty_cnt_inc == RC_W'(RTY_EVERY));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block is defaulted first; a path that left
    // one unassigned would infer a latch.
    state_d  = state_q;
    accept   = 1'b0;
    fire     = 1'b0;
    wait_dec = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q != 8'd0) begin
          wait_dec = 1'b1;
        end else begin
          fire    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    resp_err = fire && !in_range;
    resp_rty = fire && in_range && rty_mark_q;
    resp_ack = fire && in_range && !rty_mark_q;
  end

  // Request latches, wait/retry counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= 8'd0;
      rty_cnt_q    <= '0;
      rty_mark_q   <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
      bus.wb_rty_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      bus.wb_ack_o <= resp_ack;
      bus.wb_err_o <= resp_err;
      bus.wb_rty_o <= resp_rty;

      if (accept) begin
        adr_q      <= bus.wb_adr_i;
        dat_q      <= bus.wb_dat_i;
        sel_q      <= bus.wb_sel_i;
        we_q       <= bus.wb_we_i;
        wait_cnt_q <= 8'(WAIT);
        if (rty_hit) begin
          rty_cnt_q  <= '0;
          rty_mark_q <= 1'b1;
        end else begin
          rty_cnt_q  <= rty_cnt_inc;
          rty_mark_q <= 1'b0;
        end
      end

      if (wait_dec) wait_cnt_q <= wait_cnt_q - 8'd1;

      if (resp_ack && !we_q)        bus.wb_dat_o <= mem[mem_idx];
      else if (resp_err || resp_rty) bus.wb_dat_o <= '0;
    end
  end

  // Byte-lane memory write on an acknowledged write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; its contents are undefined until
    // written, which keeps it mappable onto plain RAM.
    if (!rst && resp_ack && we_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (sel_q[k]) mem[mem_idx][8*k +: 8] <= dat_q[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wshb_slave_mem.sv
// Scoreboard bench for wshb_slave_mem: a driver issues requests and queues the
// response predicted by a byte-addressed reference model; a monitor pops and
// compares whenever a termination appears on the bus.
module tb_wshb_slave_mem;

  localparam int DW     = 64;
  localparam int AW     = 32;
  localparam int DEPTH  = 1024;
  localparam int WAIT_C = 3;
  localparam int RTY_C  = 3;
  localparam int LAT    = 1 + WAIT_C;

  localparam int K_ACK = 0;
  localparam int K_ERR = 1;
  localparam int K_RTY = 2;

  typedef struct {
    int          kind;
    bit          is_read;
    bit          data_known;
    logic [63:0] data;
    int          req_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_slave_mem_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  wshb_slave_mem #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .WAIT(WAIT_C), .RTY_EVERY(RTY_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       sb[$];
  logic [7:0] mm [int];   // reference memory, keyed by byte address
  int checks    = 0;
  int failures  = 0;
  int edge_n    = 0;
  int term_cnt  = 0;
  int req_count = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every termination must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        automatic logic [2:0] t = {bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o};
        if (t != 3'b000) begin
          automatic int kind = bus.wb_ack_o ? K_ACK : (bus.wb_err_o ? K_ERR : K_RTY);
          term_cnt++;
          check("term_onehot", 64'($countones(t)), 64'(1));
          if (sb.size() == 0) begin
            check("unexpected_term", 64'(t), 64'(0));
          end else begin
            automatic exp_t e = sb.pop_front();
            check("term_kind", 64'(kind), 64'(e.kind));
            check("term_latency", 64'(edge_n - e.req_edge), 64'(LAT));
            if (e.kind != K_ACK)
              check("dat_zero_on_err_rty", bus.wb_dat_o, 64'(0));
            else if (e.is_read && e.data_known)
              check("read_data", bus.wb_dat_o, e.data);
          end
        end
      end
    end
  end

  // Reference model: response kind from range and request count, memory as bytes.
  function automatic exp_t predict(input logic [31:0] adr, input bit we,
                                   input logic [63:0] dat, input logic [7:0] sel);
    exp_t e;
    logic [31:0] idx = adr / 8;
    bit in_range = idx < DEPTH;
    bit retry;
    req_count++;
    retry = (RTY_C > 0) && (req_count % RTY_C == 0);
    e.kind       = !in_range ? K_ERR : (retry ? K_RTY : K_ACK);
    e.is_read    = !we;
    e.data_known = 1'b1;
    e.data       = '0;
    for (int k = 0; k < 8; k++) begin
      automatic int ba = int'(idx) * 8 + k;
      if (e.kind == K_ACK && we && sel[k]) mm[ba] = dat[8*k +: 8];
      if (e.kind == K_ACK && !we) begin
        if (mm.exists(ba)) e.data[8*k +: 8] = mm[ba];
        else               e.data_known = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] adr, input bit we,
                       input logic [63:0] dat, input logic [7:0] sel);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  // One complete transfer: request, bounded wait for termination, idle edge.
  task automatic do_req(input logic [31:0] adr, input bit we,
                        input logic [63:0] dat, input logic [7:0] sel);
    exp_t e;
    bit got = 1'b0;
    @(negedge clk);
    drive(adr, we, dat, sel);
    e = predict(adr, we, dat, sel);
    e.req_edge = edge_n + 1;
    sb.push_back(e);
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o || bus.wb_err_o || bus.wb_rty_o) got = 1'b1;
    end
    if (!got) check("term_timeout", 64'(got), 64'(1));
    release_bus();
    @(posedge clk);
  endtask

  // Write request abandoned by dropping cyc two cycles after acceptance.
  task automatic do_abort(input logic [31:0] adr, input logic [63:0] dat);
    int ts;
    @(negedge clk);
    drive(adr, 1'b1, dat, 8'hFF);
    req_count++;
    ts = term_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_bus();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_term", 64'(term_cnt - ts), 64'(0));
  endtask

  // Reset asserted while a read is waiting: everything drops, nothing answers.
  task automatic do_reset_mid(input logic [31:0] adr);
    int ts;
    @(negedge clk);
    drive(adr, 1'b0, '0, 8'hFF);
    ts = term_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    release_bus();
    @(posedge clk); #1;
    check("rst_mid_ack", 64'(bus.wb_ack_o), 64'(0));
    check("rst_mid_err", 64'(bus.wb_err_o), 64'(0));
    check("rst_mid_rty", 64'(bus.wb_rty_o), 64'(0));
    check("rst_mid_dat", bus.wb_dat_o, 64'(0));
    rst = 1'b0;
    req_count = 0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_no_term", 64'(term_cnt - ts), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    release_bus();
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 64'(bus.wb_ack_o), 64'(0));
    check("reset_err", 64'(bus.wb_err_o), 64'(0));
    check("reset_rty", 64'(bus.wb_rty_o), 64'(0));
    check("reset_dat", bus.wb_dat_o, 64'(0));
    rst = 1'b0;
    req_count = 0;

    // Full write/read, retry on the third request, byte-lane merge.
    do_req(32'h10, 1'b1, 64'h1122334455667788, 8'hFF);
    do_req(32'h10, 1'b0, '0, 8'hFF);
    do_req(32'h10, 1'b0, '0, 8'hFF);
    do_req(32'h10, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_req(32'h10, 1'b0, '0, 8'h00);
    // Range boundary: index 1024 errors, index 1023 acks; retried write is dropped.
    do_req(32'h2000, 1'b1, 64'hDEADBEEFDEADBEEF, 8'hFF);
    do_req(32'h2000, 1'b0, '0, 8'hFF);
    do_req(32'h1FF8, 1'b1, 64'h0123456789ABCDEF, 8'hFF);
    do_req(32'h1FF8, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_req(32'h1FF8, 1'b0, '0, 8'hFF);
    // Six back-to-back reads exercise the retry period.
    for (int i = 0; i < 6; i++) do_req(32'h10, 1'b0, '0, 8'hFF);

    // Abort leaves memory untouched.
    do_req(32'h18, 1'b1, 64'h5555666677778888, 8'hFF);
    do_abort(32'h18, 64'h0BADF00D0BADF00D);
    do_req(32'h18, 1'b0, '0, 8'hFF);
    do_req(32'h18, 1'b0, '0, 8'hFF);

    // Reset during the wait phase, then normal service resumes.
    do_reset_mid(32'h10);
    do_req(32'h10, 1'b0, '0, 8'hFF);
    do_req(32'h18, 1'b0, '0, 8'hFF);

    // Randomised traffic over a small window plus range edges.
    for (int n = 0; n < 80; n++) begin
      automatic int r = int'($urandom_range(0, 9));
      automatic logic [31:0] adr;
      if (r <= 6)      adr = 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      else if (r == 7) adr = 32'h1FF8 + 32'($urandom_range(0, 7));
      else if (r == 8) adr = 32'h2000 + 32'($urandom_range(0, 255));
      else             adr = 32'h8000_0000 | 32'($urandom);
      do_req(adr, 1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)}, 8'($urandom));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
